// File: rtl/mac_seq_ctrl_if.sv
// Operand/accumulator bundle between the operand source, mac_seq_ctrl and the accumulator register.
// No latency of its own: a plain wire bundle.
// Backpressure is carried by in_ready; the master side owns start/len/operands and the feedback value.
interface mac_seq_ctrl_if #(
    parameter int OP_W  = 4,
    parameter int ACC_W = 12,
    parameter int CNT_W = 5
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic [ACC_W-1:0] tacc_in;
    logic [ACC_W-1:0] tadd;
    logic             ld_acc;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, len, in_valid, a, b, tacc_in,
        input  in_ready, tadd, ld_acc, busy, done, ovf
    );

    modport slave (
        input  start, len, in_valid, a, b, tacc_in,
        output in_ready, tadd, ld_acc, busy, done, ovf
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Operand sequencer + multiply/add stage feeding a 12-bit accumulator register (MAC_SAT_EN: saturate + sticky ovf).
// Latency: product registered one cycle after handshake, ld_acc the cycle after; done two cycles after the last term.
// Backpressure: in_ready only in RUN; one pair per cycle sustained with no stall, in_valid ignored elsewhere.
module mac_seq_ctrl #(
    parameter int OP_W  = 4,
    parameter int ACC_W = 12,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    mac_seq_ctrl_if.slave  bus
);
    localparam int PROD_W = 2 * OP_W;
`ifdef MAC_SAT_EN
    localparam int SUM_W = ACC_W + 1;
`else
    localparam int SUM_W = ACC_W;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    len_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_inc;
    logic [PROD_W-1:0]   prod_q;
    logic                prod_vld_q;
    logic                first_q;
    logic                start_go;
    logic                accept;
    logic [ACC_W-1:0]    acc_term;
    logic [SUM_W-1:0]    sum;
    logic [ACC_W-1:0]    result;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_go     = 1'b0;
        accept       = 1'b0;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    start_go = 1'b1;
                    state_d  = (bus.len == '0) ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (accept && (cnt_inc == len_q)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A zero-length burst still issues one load of 0 so the accumulator ends cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            cnt_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            first_q    <= 1'b0;
        end else if (start_go) begin
            len_q      <= bus.len;
            cnt_q      <= '0;
            prod_q     <= '0;
            first_q    <= 1'b1;
            prod_vld_q <= (bus.len == '0);
        end else if (accept) begin
            prod_q     <= PROD_W'(bus.a) * PROD_W'(bus.b);
            prod_vld_q <= 1'b1;
            first_q    <= (cnt_q == '0);
            cnt_q      <= cnt_inc;
        end else begin
            prod_vld_q <= 1'b0;
        end
    end

    // The first term ignores the feedback, so each burst overwrites the previous result.
    assign acc_term = first_q ? '0 : bus.tacc_in;
    assign sum      = SUM_W'(acc_term) + SUM_W'(prod_q);

`ifdef MAC_SAT_EN
    logic ovf_q;

    assign result = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (start_go) begin
            ovf_q <= 1'b0;
        end else if (prod_vld_q && sum[ACC_W]) begin
            ovf_q <= 1'b1;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign result  = sum;
    assign bus.ovf = 1'b0;
`endif

    assign bus.ld_acc = prod_vld_q;
    assign bus.tadd   = prod_vld_q ? result : '0;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural accumulator register closing the feedback loop.
// Build with +define+MAC_SAT_EN to exercise the saturating variant.
module tb_mac_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = -1;
    int   start_cyc = -1;
    bit   saw_ready = 1'b0;
    int   ld_tadd[$];
    int   ld_cyc[$];
    int   hs_cyc[$];
    logic [11:0] acc = '0;

    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.OP_W(4), .ACC_W(12), .CNT_W(5)) bus ();

    mac_seq_ctrl #(.OP_W(4), .ACC_W(12), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Accumulator register downstream of the block; not cleared by rst.
    always @(posedge clk) if (bus.ld_acc) acc <= bus.tadd;
    assign bus.tacc_in = acc;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.ld_acc) begin
            ld_tadd.push_back(int'(bus.tadd));
            ld_cyc.push_back(cyc);
        end
        if (bus.done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (bus.in_ready) saw_ready = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ld_at(input int i);
        return (i < ld_tadd.size()) ? ld_tadd[i] : -1;
    endfunction

    task automatic clear_log();
        ld_tadd.delete();
        ld_cyc.delete();
        hs_cyc.delete();
        saw_ready = 1'b0;
    endtask

    task automatic do_start(input int n);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.len   = 5'(n);
        @(negedge clk); #1;
        start_cyc = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send(input string tag, input int aa, input int bb, input int gap);
        bit got;
        got = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.a = 4'(aa);
        bus.b = 4'(bb);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk); #1;
            if (bus.in_ready) begin
                hs_cyc.push_back(cyc);
                got = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!got) check({tag, "_hs_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string tag, input int exp_acc, input int exp_ovf);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk); #1;
            if (bus.done) got = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(got), 1);
        check({tag, "_acc"}, 32'(acc), 32'(exp_acc));
        check({tag, "_busy_in_done"}, 32'(bus.busy), 1);
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        @(posedge clk); #1;
        check({tag, "_idle_after"}, 32'(bus.busy), 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_ld_acc",   32'(bus.ld_acc), 0);
        check("rst_busy",     32'(bus.busy), 0);
        check("rst_done",     32'(bus.done), 0);
        check("rst_ovf",      32'(bus.ovf), 0);
        check("rst_tadd",     32'(bus.tadd), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Basic back-to-back burst.
        clear_log();
        do_start(3);
        send("basic", 2, 3, 0);
        send("basic", 4, 5, 0);
        send("basic", 1, 7, 0);
        wait_done("basic", 33, 0);
        check("basic_nld", 32'(ld_tadd.size()), 3);
        check("basic_tadd0", 32'(ld_at(0)), 6);
        check("basic_tadd1", 32'(ld_at(1)), 26);
        check("basic_tadd2", 32'(ld_at(2)), 33);
        check("basic_done_lat", 32'(done_cyc - ((hs_cyc.size() == 3) ? hs_cyc[2] : 0)), 2);

        // Gaps between pairs.
        clear_log();
        do_start(2);
        send("stall", 15, 15, 3);
        send("stall", 15, 15, 3);
        wait_done("stall", 450, 0);
        check("stall_nld", 32'(ld_tadd.size()), 2);
        check("stall_tadd0", 32'(ld_at(0)), 225);
        check("stall_tadd1", 32'(ld_at(1)), 450);
        for (int i = 0; i < 2; i++) begin
            if (i < ld_cyc.size() && i < hs_cyc.size())
                check("stall_ld_after_hs", 32'(ld_cyc[i] - hs_cyc[i]), 1);
            else
                check("stall_ld_log", 0, 1);
        end

        // New burst overwrites the previous result.
        clear_log();
        do_start(1);
        send("ovwr", 3, 3, 0);
        wait_done("ovwr", 9, 0);
        check("ovwr_tadd0", 32'(ld_at(0)), 9);

        // Zero-length burst.
        clear_log();
        do_start(0);
        wait_done("len0", 0, 0);
        check("len0_nld", 32'(ld_tadd.size()), 1);
        check("len0_tadd", 32'(ld_at(0)), 0);
        check("len0_ld_cyc", 32'((ld_cyc.size() > 0) ? ld_cyc[0] - start_cyc : -1), 1);
        check("len0_done_cyc", 32'(done_cyc - start_cyc), 2);
        check("len0_no_ready", 32'(saw_ready), 0);

        // 20 x 225 = 4500 overflows 12 bits.
        clear_log();
        do_start(20);
        for (int i = 0; i < 20; i++) send("ovf", 15, 15, 0);
`ifdef MAC_SAT_EN
        wait_done("ovf", 4095, 1);
        check("ovf_tadd18", 32'(ld_at(18)), 4095);
`else
        wait_done("ovf", 404, 0);
        check("ovf_tadd18", 32'(ld_at(18)), 179);
`endif
        check("ovf_nld", 32'(ld_tadd.size()), 20);

        // Reset during RUN after 2 of 5 terms.
        clear_log();
        do_start(5);
        send("rstmid", 2, 3, 0);
        send("rstmid", 1, 1, 0);
        begin
            int dc;
            dc = done_cnt;
            rst = 1'b0;
            #1;
            check("rstmid_busy", 32'(bus.busy), 0);
            check("rstmid_ld_acc", 32'(bus.ld_acc), 0);
            check("rstmid_in_ready", 32'(bus.in_ready), 0);
            check("rstmid_tadd", 32'(bus.tadd), 0);
            @(posedge clk); #1;
            rst = 1'b1;
            repeat (5) begin
                @(posedge clk); #1;
            end
            check("rstmid_no_done", 32'(done_cnt - dc), 0);
            check("rstmid_acc_kept", 32'(acc), 6);
        end
        clear_log();
        do_start(1);
        send("after_rst", 2, 2, 0);
        wait_done("after_rst", 4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
